// File: rtl/accel_rr_sched_if.sv
// Bus bundle between the round-robin scheduler, its two requesters and the accelerator core.
interface accel_rr_sched_if;
    logic [1:0] req;
    logic [1:0] grant;
    logic       accel_start;
    logic       accel_done;
    logic [3:0] accel_digit;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_digit;
    logic       rsp_err;
    logic       busy;

    // Scheduler side.
    modport master (
        input  req,
        input  accel_done,
        input  accel_digit,
        input  rsp_ready,
        output grant,
        output accel_start,
        output rsp_valid,
        output rsp_id,
        output rsp_digit,
        output rsp_err,
        output busy
    );

    // Requester / accelerator side.
    modport slave (
        output req,
        output accel_done,
        output accel_digit,
        output rsp_ready,
        input  grant,
        input  accel_start,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_digit,
        input  rsp_err,
        input  busy
    );
endinterface

// File: rtl/accel_rr_sched.sv
// Two-requester round-robin scheduler for a shared inference accelerator.
// One transaction at a time: arbitrate, pulse start, wait for a done rising
// edge (or time out), then hold the result until the owner accepts it.
module accel_rr_sched #(
    parameter int unsigned TIMEOUT_CYC = 2047
) (
    input  logic             clk,
    input  logic             rst,
    accel_rr_sched_if.master bus
);
    localparam int unsigned CNT_W = 12;
    localparam int unsigned DIG_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [DIG_W-1:0] DIG_ERR  = DIG_W'(4'hF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               start_q, start_d;
    logic               valid_q, valid_d;
    logic               id_q, id_d;
    logic [DIG_W-1:0]   digit_q, digit_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               done_q;
    logic               done_rise;
    logic               winner;

    // Round-robin pick: a lone requester wins, a tie goes away from last_id.
    always_comb begin
        winner = ~last_q;
        if (bus.req == 2'b01) begin
            winner = 1'b0;
        end else if (bus.req == 2'b10) begin
            winner = 1'b1;
        end
    end

    // Only a fresh 0->1 transition of done counts; a held level is ignored.
    assign done_rise = bus.accel_done & ~done_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        start_d = 1'b0;
        valid_d = valid_q;
        id_d    = id_q;
        digit_d = digit_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                    grant_d = winner ? 2'b10 : 2'b01;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // Done beats a timeout landing on the same cycle.
                if (done_rise) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    id_d    = grant_q[1];
                    digit_d = bus.accel_digit;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    id_d    = grant_q[1];
                    digit_d = DIG_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    valid_d = 1'b0;
                    last_d  = grant_q[1];
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            digit_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            start_q <= start_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            digit_q <= digit_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= bus.accel_done;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.accel_start = start_q;
    assign bus.rsp_valid   = valid_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_digit   = digit_q;
    assign bus.rsp_err     = err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_accel_rr_sched.sv
// Bench for accel_rr_sched: a long-timeout and a short-timeout instance share
// stimulus; only the selected one sees requests. Expected behaviour comes from
// a transaction-level model (round-robin owner, done-vs-timeout rule).
module tb_accel_rr_sched;
    localparam int BIG_TO   = 2047;
    localparam int SMALL_TO = 8;

    logic       clk = 1'b0;
    logic       rst_v = 1'b1;
    logic       sel = 1'b0;
    logic [1:0] req_v = 2'b00;
    logic       done_v = 1'b0;
    logic [3:0] digit_v = 4'h0;
    logic       ready_v = 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    bit m_last [2];

    accel_rr_sched_if ifb ();
    accel_rr_sched_if ifs ();

    accel_rr_sched #(.TIMEOUT_CYC(BIG_TO)) dut_big (
        .clk (clk),
        .rst (rst_v),
        .bus (ifb.master)
    );

    accel_rr_sched #(.TIMEOUT_CYC(SMALL_TO)) dut_small (
        .clk (clk),
        .rst (rst_v),
        .bus (ifs.master)
    );

    assign ifb.req         = sel ? 2'b00 : req_v;
    assign ifs.req         = sel ? req_v : 2'b00;
    assign ifb.accel_done  = done_v;
    assign ifs.accel_done  = done_v;
    assign ifb.accel_digit = digit_v;
    assign ifs.accel_digit = digit_v;
    assign ifb.rsp_ready   = ready_v;
    assign ifs.rsp_ready   = ready_v;

    wire [1:0] grant_o = sel ? ifs.grant       : ifb.grant;
    wire       start_o = sel ? ifs.accel_start : ifb.accel_start;
    wire       valid_o = sel ? ifs.rsp_valid   : ifb.rsp_valid;
    wire       id_o    = sel ? ifs.rsp_id      : ifb.rsp_id;
    wire [3:0] digit_o = sel ? ifs.rsp_digit   : ifb.rsp_digit;
    wire       err_o   = sel ? ifs.rsp_err     : ifb.rsp_err;
    wire       busy_o  = sel ? ifs.busy        : ifb.busy;
    wire       idle_busy = sel ? ifb.busy      : ifs.busy;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick(input logic [1:0] rq, input bit last);
        if (rq == 2'b01) return 1'b0;
        if (rq == 2'b10) return 1'b1;
        return ~last;
    endfunction

    task automatic chk_reset_outs();
        chk("rst_grant", 32'(grant_o), 32'(0));
        chk("rst_start", 32'(start_o), 32'(0));
        chk("rst_valid", 32'(valid_o), 32'(0));
        chk("rst_id",    32'(id_o),    32'(0));
        chk("rst_digit", 32'(digit_o), 32'(0));
        chk("rst_err",   32'(err_o),   32'(0));
        chk("rst_busy",  32'(busy_o),  32'(0));
    endtask

    // One full transaction. done_at = WAIT cycle (1-based) on which done rises, 0 = never.
    task automatic run_txn(input logic [1:0] rq, input int done_at, input bit pulse,
                           input logic [3:0] dig, input int ready_lat);
        int         to;
        int         nwait;
        bit         ew;
        logic [1:0] eg;
        bit         exp_err;
        logic [3:0] exp_dig;

        to = sel ? SMALL_TO : BIG_TO;
        ew = pick(rq, m_last[sel]);
        eg = ew ? 2'b10 : 2'b01;
        if (done_at >= 1 && done_at <= to) begin
            nwait = done_at; exp_err = 1'b0; exp_dig = dig;
        end else begin
            nwait = to; exp_err = 1'b1; exp_dig = 4'hF;
        end

        req_v   = rq;
        digit_v = dig;
        tick();
        chk("grant",     32'(grant_o), 32'(eg));
        chk("start_hi",  32'(start_o), 32'(1));
        chk("busy_st",   32'(busy_o),  32'(1));
        chk("valid_st",  32'(valid_o), 32'(0));
        req_v   = 2'($urandom);
        ready_v = 1'($urandom);
        tick();

        for (int k = 1; k <= nwait; k++) begin
            chk("start_lo",  32'(start_o), 32'(0));
            chk("valid_w",   32'(valid_o), 32'(0));
            chk("grant_w",   32'(grant_o), 32'(eg));
            if (k == 1 || k == nwait) chk("busy_w", 32'(busy_o), 32'(1));
            if (k == done_at) done_v = 1'b1;
            req_v   = 2'($urandom);
            ready_v = 1'($urandom);
            tick();
        end

        if (pulse) done_v = 1'b0;
        for (int r = 0; r <= ready_lat; r++) begin
            chk("rsp_valid", 32'(valid_o), 32'(1));
            chk("rsp_id",    32'(id_o),    32'(ew));
            chk("rsp_digit", 32'(digit_o), 32'(exp_dig));
            chk("rsp_err",   32'(err_o),   32'(exp_err));
            chk("grant_r",   32'(grant_o), 32'(eg));
            chk("start_r",   32'(start_o), 32'(0));
            req_v   = (r == ready_lat) ? 2'b00 : 2'($urandom);
            ready_v = (r == ready_lat);
            digit_v = 4'($urandom);
            tick();
        end

        chk("hs_valid", 32'(valid_o), 32'(0));
        chk("hs_grant", 32'(grant_o), 32'(0));
        chk("hs_busy",  32'(busy_o),  32'(0));
        chk("hs_id",    32'(id_o),    32'(ew));
        chk("hs_digit", 32'(digit_o), 32'(exp_dig));
        chk("hs_err",   32'(err_o),   32'(exp_err));
        chk("other_idle", 32'(idle_busy), 32'(0));
        m_last[sel] = ew;
        ready_v = 1'b0;
        done_v  = 1'b0;
    endtask

    initial begin
        m_last[0] = 1'b1;
        m_last[1] = 1'b1;
        rst_v = 1'b1;
        repeat (3) tick();
        chk_reset_outs();
        rst_v = 1'b0;
        tick();
        chk_reset_outs();

        // Long-timeout instance: nominal inference, ties, slow consumer, stuck done.
        sel = 1'b0;
        run_txn(2'b01, 830, 1'b0, 4'h6, 0);
        for (int i = 0; i < 4; i++) run_txn(2'b11, 3 + i, 1'b1, 4'(i + 1), 0);
        run_txn(2'b10, 20, 1'b1, 4'h3, 50);
        done_v = 1'b1;
        repeat (2) tick();
        done_v = 1'b1;
        run_txn(2'b01, 0, 1'b0, 4'h5, 2);
        for (int i = 0; i < 6; i++)
            run_txn(2'($urandom_range(1, 3)), int'($urandom_range(1, 100)),
                    1'($urandom), 4'($urandom), int'($urandom_range(0, 4)));

        // Short-timeout instance: done on the last WAIT cycle, just after, and random.
        sel = 1'b1;
        tick();
        run_txn(2'b01, 8, 1'b1, 4'h9, 1);
        run_txn(2'b10, 9, 1'b0, 4'h2, 0);
        run_txn(2'b11, 7, 1'b0, 4'hA, 3);
        run_txn(2'b11, 1, 1'b1, 4'h4, 0);
        for (int i = 0; i < 30; i++)
            run_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 11)),
                    1'($urandom), 4'($urandom), int'($urandom_range(0, 5)));

        // Reset in the middle of WAIT after requester 0 was served last.
        sel = 1'b0;
        tick();
        run_txn(2'b01, 4, 1'b1, 4'h7, 0);
        req_v = 2'b10;
        tick();
        chk("pre_rst_grant", 32'(grant_o), 32'(2'b10));
        req_v = 2'b00;
        repeat (6) tick();
        rst_v = 1'b1;
        tick();
        chk_reset_outs();
        m_last[0] = 1'b1;
        m_last[1] = 1'b1;
        rst_v = 1'b0;
        tick();
        chk("post_rst_start", 32'(start_o), 32'(0));
        run_txn(2'b11, 5, 1'b0, 4'h9, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/accel_rr_sched.md
ACCEL_RR_SCHED -- requirements
Module: accel_rr_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 2047, max cycles waited for accelerator done before abort (range 1..4095).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-requester inference request, level; bit0 = host port, bit1 = on-board test port.
REQ-005 grant  output  2  one-hot ownership of accelerator and image path; 2'b00 when unowned.
REQ-006 accel_start  output  1  start pulse to accelerator core.
REQ-007 accel_done  input  1  accelerator done, level or pulse.
REQ-008 accel_digit  input  4  accelerator prediction, valid when done rises.
REQ-009 rsp_valid  output  1  result available to granted requester.
REQ-010 rsp_ready  input  1  result accepted.
REQ-011 rsp_id  output  1  index of requester the result belongs to.
REQ-012 rsp_digit  output  4  predicted digit, 4'hF on error.
REQ-013 rsp_err  output  1  result produced by timeout abort.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, START, WAIT, RESP; encoding free.
REQ-016 IDLE: if req != 0 at edge N, winner SHALL be latched, grant one-hot from N+1, state START.
REQ-017 Arbitration SHALL be round-robin: single requester wins outright; both requesting -> requester other than last_id wins.
REQ-018 last_id SHALL update to the winner on the rsp_valid&rsp_ready handshake only.
REQ-019 START: accel_start SHALL be high exactly one cycle (N+1), then state WAIT unconditionally.
REQ-020 WAIT: timeout counter (12 bit) SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-021 Done SHALL be qualified only as rising edge (accel_done=1, registered previous value=0) while in WAIT; a done level held over from a prior inference SHALL be ignored.
REQ-022 Qualified done: accel_digit captured into rsp_digit, rsp_err=0, state RESP next cycle.
REQ-023 Counter reaching TIMEOUT_CYC without qualified done: rsp_digit=4'hF, rsp_err=1, state RESP.
REQ-024 Done and timeout in the same cycle: done SHALL win (rsp_err=0).
REQ-025 RESP: rsp_valid, rsp_id, rsp_digit, rsp_err SHALL hold stable until rsp_valid&rsp_ready.
REQ-026 Handshake cycle: next cycle state IDLE, grant=0, rsp_valid=0; rsp_digit/rsp_id/rsp_err retain last value.
REQ-027 Grant SHALL stay constant from START through handshake; deassertion of req by the owner SHALL NOT abort or shorten the transaction.
REQ-028 New requests SHALL NOT be arbitrated before returning to IDLE; minimum gap between two accel_start pulses = 4 cycles.
REQ-029 rsp_ready outside RESP SHALL be ignored.

Reset
REQ-030 On rst: state IDLE, grant=0, accel_start=0, rsp_valid=0, rsp_id=0, rsp_digit=0, rsp_err=0, busy=0, counter=0, done-edge register=0, last_id=1 (requester 0 wins first tie).
REQ-031 rst in any state, including mid-WAIT or mid-RESP, SHALL take effect next edge; pending result discarded, no accel_start issued.

Verification
REQ-032 req=2'b01 one cycle, done rises 830 cycles after start with digit 6, rsp_ready=1 -> grant=01 one cycle after req, one accel_start pulse, rsp_valid with id 0, digit 6, err 0; busy drops after handshake.
REQ-033 req=2'b11 held, rsp_ready=1 -> grants alternate 01,10,01,10 over four transactions; rsp_id follows grant.
REQ-034 accel_done stuck high before start, never falls -> no qualified done; after TIMEOUT_CYC WAIT cycles rsp_valid, rsp_err=1, rsp_digit=F.
REQ-035 TIMEOUT_CYC=8, done rises on the 8th WAIT cycle -> rsp_err=0, captured digit returned.
REQ-036 rsp_ready=0 for 50 cycles in RESP, req toggling -> outputs stable, grant unchanged, no new accel_start; handshake then returns to IDLE.
REQ-037 rst asserted mid-WAIT -> next cycle all outputs at reset values; subsequent req=2'b11 grants requester 0.
